// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/data memory arbiter.
// Holds the FSM state encoding, the read value returned on an abandoned
// access, and the packed bus command carried from request to completion.
package mem_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] INST = 2'd2;

  // Read data substituted when an access times out without bus_ack
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Bus command captured when an access starts and held until it completes
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/mem_arbiter_wait_cnt.sv
// arb_wait_cnt: bus wait counter with terminal flag at TIMEOUT_CYC.
// Latency: clear/increment take effect on the next clock; term is combinational from the count.
// Backpressure: none; saturates at TIMEOUT_CYC until cleared.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count (takes priority over inc)
//   inc        : advance the count by one
//   term       : count has reached TIMEOUT_CYC
module arb_wait_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TERM_VAL = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign term = (cnt_q == TERM_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !term) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between IF fetches and MEM loads/stores.
// Latency: request seen in cycle 0, bus_req in cycle 1; ack in cycle 1+w drops stall in cycle 2+w.
// Backpressure: stall freezes the pipeline while any request is unserved; data is served before fetch.
//
// Optional feature: define MEM_ARB_IBUF_EN for a one-entry instruction buffer
// (hits return the buffered word the same cycle with no bus access).
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   inst_ren, inst_addr           : fetch request / address
//   inst_data                     : fetched instruction
//   mem_ren, mem_wen              : load / store request
//   mem_addr, mem_dout            : data address / store data
//   mem_din                       : load data
//   stall                         : pipeline freeze
//   bus_req, bus_we, bus_addr,
//   bus_wdata                     : memory request
//   bus_rdata, bus_ack            : memory response
//   timeout_err                   : sticky, set by any timed-out access
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        timeout_err
);

  logic [1:0]  state_q, state_d;
  bus_cmd_t    bus_cmd_q, bus_cmd_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        data_done_q, data_done_d;
  logic        inst_done_q, inst_done_d;
  logic        timeout_err_q, timeout_err_d;

  logic        busy;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        cnt_term;
  logic        done_evt;
  logic        timed_out;
  logic [31:0] rdata_eff;
  logic        data_pend;
  logic        inst_pend;
  logic        ibuf_hit;

  assign busy      = (state_q != IDLE);
  // A timeout only counts when no ack arrives in the same cycle; ack wins.
  assign timed_out = busy && !bus_ack && cnt_term;
  assign done_evt  = busy && (bus_ack || cnt_term);
  assign rdata_eff = bus_ack ? bus_rdata : TIMEOUT_RDATA;

  assign cnt_clr = (state_q == IDLE) && (state_d != IDLE);
  assign cnt_inc = busy && !bus_ack;

  arb_wait_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (cnt_term)
  );

`ifdef MEM_ARB_IBUF_EN
  logic        ibuf_vld_q, ibuf_vld_d;
  logic [29:0] ibuf_tag_q, ibuf_tag_d;
  logic [31:0] ibuf_dat_q, ibuf_dat_d;

  assign ibuf_hit = ibuf_vld_q && inst_ren && (inst_addr[31:2] == ibuf_tag_q);

  always_comb begin
    ibuf_vld_d = ibuf_vld_q;
    ibuf_tag_d = ibuf_tag_q;
    ibuf_dat_d = ibuf_dat_q;
    if (state_q == INST && done_evt) begin
      ibuf_vld_d = 1'b1;
      ibuf_tag_d = bus_cmd_q.addr[31:2];
      ibuf_dat_d = rdata_eff;
    end else if (state_q == DATA && done_evt && bus_cmd_q.we &&
                 bus_cmd_q.addr[31:2] == ibuf_tag_q) begin
      // A store to the buffered word makes the copy stale.
      ibuf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibuf_vld_q <= 1'b0;
      ibuf_tag_q <= '0;
      ibuf_dat_q <= '0;
    end else begin
      ibuf_vld_q <= ibuf_vld_d;
      ibuf_tag_q <= ibuf_tag_d;
      ibuf_dat_q <= ibuf_dat_d;
    end
  end

  // A hit must be visible in the same cycle it is requested.
  assign inst_data = ibuf_hit ? ibuf_dat_q : inst_data_q;
`else
  assign ibuf_hit  = 1'b0;
  assign inst_data = inst_data_q;
`endif

  assign data_pend = (mem_ren || mem_wen) && !data_done_q;
  assign inst_pend = inst_ren && !inst_done_q && !ibuf_hit;
  assign stall     = data_pend || inst_pend;

  always_comb begin
    state_d       = state_q;
    bus_cmd_d     = bus_cmd_q;
    inst_data_d   = inst_data_q;
    mem_din_d     = mem_din_q;
    timeout_err_d = timeout_err_q || timed_out;
    // Done flags live only until the pipeline advances (stall low at an edge).
    data_done_d   = stall ? data_done_q : 1'b0;
    inst_done_d   = stall ? inst_done_q : 1'b0;

    // Keep the registered fetch result consistent with a buffer hit.
    if (ibuf_hit) begin
      inst_data_d = inst_data;
    end

    case (state_q)
      IDLE: begin
        if (data_pend) begin
          state_d         = DATA;
          bus_cmd_d.we    = mem_wen;
          bus_cmd_d.addr  = mem_addr;
          bus_cmd_d.wdata = mem_dout;
        end else if (inst_pend) begin
          state_d         = INST;
          bus_cmd_d.we    = 1'b0;
          bus_cmd_d.addr  = inst_addr;
          bus_cmd_d.wdata = '0;
        end
      end
      DATA: begin
        if (done_evt) begin
          state_d     = IDLE;
          data_done_d = 1'b1;
          if (!bus_cmd_q.we) begin
            mem_din_d = rdata_eff;
          end
        end
      end
      INST: begin
        if (done_evt) begin
          state_d     = IDLE;
          inst_done_d = 1'b1;
          inst_data_d = rdata_eff;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bus_cmd_q     <= '0;
      inst_data_q   <= '0;
      mem_din_q     <= '0;
      data_done_q   <= 1'b0;
      inst_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_cmd_q     <= bus_cmd_d;
      inst_data_q   <= inst_data_d;
      mem_din_q     <= mem_din_d;
      data_done_q   <= data_done_d;
      inst_done_q   <= inst_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus_req     = busy;
  assign bus_we      = bus_cmd_q.we;
  assign bus_addr    = bus_cmd_q.addr;
  assign bus_wdata   = bus_cmd_q.wdata;
  assign mem_din     = mem_din_q;
  assign timeout_err = timeout_err_q;

endmodule
